hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 29 ++
 rtl/hazard_scoreboard_sat_counter.sv | 35 +++
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the pipeline hazard scoreboard: FSM states, shadow-slot
// layout and the source-operand match helper.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } hs_state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             memread;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic src_match(
        input logic             used,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] rd
    );
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Up-counter with synchronous clear that saturates at all-ones instead of
// wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / branch / memory-wait hazard controller. Tracks the EX and MEM
// pipeline contents in shadow slots and drives stall, bubble, flush and freeze.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_branch_taken,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             freeze,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hs_state_e         state_q;
    hs_state_e         state_d;
    slot_t             ex_q;
    slot_t             ex_d;
    slot_t             mem_q;
    slot_t             mem_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              load_use;
    logic              unused_id_regwrite;

    // Loads always write rd, so the write-enable adds nothing to hazard detection.
    assign unused_id_regwrite = id_regwrite;

    assign mem_wait = mem_q.valid && mem_q.memread && !mem_ready;

    assign load_use = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                      (src_match(id_rs1_used, id_rs1, ex_q.rd) ||
                       src_match(id_rs2_used, id_rs2, ex_q.rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ERROR;
                end
            end
            ERROR: state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    // Outputs are gated by rst_n so a branch input cannot leak through during reset.
    always_comb begin
        pc_stall        = 1'b0;
        if_id_stall     = 1'b0;
        id_ex_bubble    = 1'b0;
        if_id_flush     = 1'b0;
        freeze          = 1'b0;
        mem_timeout_err = 1'b0;
        if (rst_n) begin
            if (state_q == ERROR) begin
                freeze          = 1'b1;
                mem_timeout_err = 1'b1;
            end else if (mem_wait) begin
                freeze = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (!freeze) begin
            mem_d = ex_q;
            if (id_ex_bubble) begin
                ex_d = SLOT_EMPTY;
            end else begin
                ex_d = '{valid: id_valid, rd: id_rd, memread: id_memread};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    sat_counter #(
        .WIDTH(WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == RUN),
        .inc   ((state_q == WAIT) && !mem_ready),
        .q     (wait_cnt)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (pc_stall || freeze),
        .q     (stall_cnt)
    );

endmodule
